map_writer: RTL and testbench



---
 rtl/map_writer.sv | 112 +++++++++++
 tb/tb_map_writer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_writer.sv
// Tile-map writer: decodes a byte command stream into a shadow tile map and
// copies the shadow to the displayed map only at a frame boundary.
module map_writer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TO_W           = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic         frame_start,
    input  logic         err_clr,
    output logic [127:0] map,
    output logic         map_updated,
    output logic         cmd_error
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD     = 2'd1;
    localparam logic [1:0] TILE_ARG = 2'd2;

    logic [1:0]      state;
    logic [127:0]    shadow;
    logic [3:0]      byte_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            commit_pending;
    logic            xfer;
    logic            timeout_hit;
    logic            op_error;

    // Holding off the sender after COMMIT keeps the shadow frozen until the copy.
    assign rx_ready    = !commit_pending;
    assign xfer        = rx_valid && rx_ready;
    assign timeout_hit = (state != IDLE) && !xfer &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign op_error    = xfer && (state == IDLE) && (rx_data > 8'h04);

    always_ff @(posedge clk) begin
        if (reset) begin
            map            <= '0;
            shadow         <= '0;
            state          <= IDLE;
            byte_cnt       <= '0;
            to_cnt         <= '0;
            commit_pending <= 1'b0;
            map_updated    <= 1'b0;
            cmd_error      <= 1'b0;
        end else begin
            map_updated <= 1'b0;
            if (commit_pending && frame_start) begin
                map            <= shadow;
                commit_pending <= 1'b0;
                map_updated    <= 1'b1;
            end

            // A new error outranks a simultaneous clear.
            if (op_error || timeout_hit) begin
                cmd_error <= 1'b1;
            end else if (err_clr) begin
                cmd_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (xfer) begin
                        case (rx_data)
                            8'h01: begin
                                state    <= LOAD;
                                byte_cnt <= '0;
                            end
                            8'h02: state <= TILE_ARG;
                            8'h03: shadow <= '0;
                            8'h04: commit_pending <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        shadow[{byte_cnt, 3'b000} +: 8] <= rx_data;
                        byte_cnt <= byte_cnt + 4'd1;
                        to_cnt   <= '0;
                        if (byte_cnt == 4'd15) begin
                            state <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                TILE_ARG: begin
                    if (xfer) begin
                        shadow[rx_data[6:0]] <= rx_data[7];
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else if (timeout_hit) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_writer.sv
// Bench for map_writer: directed and random command streams against a tile-map
// reference model; a monitor checks every map_updated against an expected queue.
module tb_map_writer;

    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         frame_start;
    logic         err_clr;
    logic [127:0] map;
    logic         map_updated;
    logic         cmd_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] m_shadow;
    logic         m_pending;
    logic         in_reset;
    logic [127:0] prev_map;

    map_writer #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_start(frame_start), .err_clr(err_clr),
        .map(map), .map_updated(map_updated), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every map_updated must match the oldest expected copy, and map
    // must never move without one.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (map_updated) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_map_updated: got map %h, no commit expected", map);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (map !== e) begin
                        n_errors++;
                        $display("FAIL map_commit: got %h expected %h", map, e);
                    end
                end
            end else if (map !== prev_map) begin
                n_checks++;
                n_errors++;
                $display("FAIL map_moved_without_commit: got %h expected %h", map, prev_map);
            end
        end
        prev_map = map;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_ready_wait: got rx_ready 0 for 200 cycles expected 1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic op_load(input int gap);
        logic [7:0] b;
        send_byte(8'h01, gap);
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, gap);
            m_shadow[8*k +: 8] = b;
        end
    endtask

    task automatic op_tile(input logic [7:0] b, input int gap);
        send_byte(8'h02, gap);
        send_byte(b, gap);
        m_shadow[b[6:0]] = b[7];
    endtask

    task automatic op_commit(input int gap);
        send_byte(8'h04, gap);
        m_pending = 1'b1;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        if (m_pending) begin
            exp_q.push_back(m_shadow);
            m_pending = 1'b0;
        end
        @(negedge clk);
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL commit_missing: got no map_updated expected %0d copies", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        @(negedge clk);
        reset       = 1'b1;
        rx_valid    = 1'b0;
        frame_start = 1'b0;
        err_clr     = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        m_shadow  = '0;
        m_pending = 1'b0;
        exp_q.delete();
        @(negedge clk);
        in_reset = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int op;
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        frame_start = 1'b0; err_clr = 1'b0;
        m_shadow = '0; m_pending = 1'b0; in_reset = 1'b1; prev_map = '0;

        // Reset state
        do_reset();
        check("reset_map", map, 128'h0);
        check("reset_map_updated", 128'(map_updated), 128'h0);
        check("reset_cmd_error", 128'(cmd_error), 128'h0);
        check("reset_rx_ready", 128'(rx_ready), 128'h1);

        // LOAD with bit 0 and bit 127, then a late frame_start
        send_byte(8'h01, 0);
        for (int k = 0; k < 16; k++) begin
            b = (k == 0) ? 8'h01 : ((k == 15) ? 8'h80 : 8'h00);
            send_byte(b, 0);
            m_shadow[8*k +: 8] = b;
        end
        op_commit(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pending_rx_ready", 128'(rx_ready), 128'h0);
            check("pending_map", map, 128'h0);
        end
        @(negedge clk);
        frame_start = 1'b1;
        exp_q.push_back(m_shadow);
        m_pending = 1'b0;
        check("map_before_copy_edge", map, 128'h0);
        @(negedge clk);
        frame_start = 1'b0;
        check("load_map", map, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
        check("load_map_updated", 128'(map_updated), 128'h1);
        check("rx_ready_after_copy", 128'(rx_ready), 128'h1);
        @(negedge clk);
        check("map_updated_one_cycle", 128'(map_updated), 128'h0);

        // TILE set then clear of tile 35
        send_byte(8'h03, 0);
        m_shadow = '0;
        op_tile(8'hA3, 0);
        op_commit(0);
        frame_pulse();
        check("tile35_map", map, 128'h8_0000_0000);
        op_tile(8'h23, 1);
        op_commit(1);
        frame_pulse();
        check("tile35_cleared", map, 128'h0);

        // COMMIT accepted in the same cycle as frame_start
        op_tile(8'h81, 0);
        @(negedge clk);
        rx_data = 8'h04; rx_valid = 1'b1; frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        rx_data = 8'h00;
        m_pending = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("same_cycle_rx_ready", 128'(rx_ready), 128'h0);
            check("same_cycle_no_copy", 128'(map_updated), 128'h0);
        end
        @(negedge clk);
        frame_start = 1'b1;
        exp_q.push_back(m_shadow);
        m_pending = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        rx_valid = 1'b0;
        check("second_frame_copies", 128'(map_updated), 128'h1);
        check("same_cycle_map", map, 128'h2);

        // Timeout in LOAD keeps the bytes already written
        send_byte(8'h03, 0);
        m_shadow = '0;
        send_byte(8'h01, 0);
        for (int k = 0; k < 5; k++) begin
            send_byte(8'hFF, 0);
            m_shadow[8*k +: 8] = 8'hFF;
        end
        repeat (TO - 6) @(negedge clk);
        check("no_early_timeout", 128'(cmd_error), 128'h0);
        repeat (14) @(negedge clk);
        check("timeout_error", 128'(cmd_error), 128'h1);
        op_commit(0);
        frame_pulse();
        check("timeout_partial_map", map, 128'hFF_FFFF_FFFF);
        pulse_err_clr();
        check("err_clr", 128'(cmd_error), 128'h0);

        // Illegal opcode, and error winning over a simultaneous clear
        send_byte(8'h7E, 0);
        check("illegal_opcode", 128'(cmd_error), 128'h1);
        op_commit(0);
        frame_pulse();
        check("illegal_shadow_kept", map, 128'hFF_FFFF_FFFF);
        @(negedge clk);
        rx_data = 8'h7E; rx_valid = 1'b1; err_clr = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        check("error_beats_clr", 128'(cmd_error), 128'h1);
        pulse_err_clr();
        check("err_clr_again", 128'(cmd_error), 128'h0);

        // Back-to-back single-cycle opcodes
        op_tile(8'h90, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        m_shadow = '0;
        op_tile(8'h91, 0);
        op_commit(0);
        frame_pulse();
        check("back_to_back", map, 128'h2_0000);

        // Randomized command mix
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            case (op)
                0: op_load($urandom_range(0, 2));
                1: op_tile(8'($urandom_range(0, 255)), $urandom_range(0, 2));
                2: begin send_byte(8'h03, $urandom_range(0, 2)); m_shadow = '0; end
                3: send_byte(8'h00, $urandom_range(0, 2));
                4: begin
                    op_commit($urandom_range(0, 3));
                    frame_pulse();
                end
                default: begin
                    send_byte(8'($urandom_range(5, 255)), 0);
                    check("rand_illegal", 128'(cmd_error), 128'h1);
                    pulse_err_clr();
                    check("rand_err_clr", 128'(cmd_error), 128'h0);
                end
            endcase
        end
        op_commit(0);
        frame_pulse();

        // Reset in the middle of a LOAD
        op_tile(8'hFF, 0);
        op_commit(0);
        frame_pulse();
        send_byte(8'h01, 0);
        for (int k = 0; k < 9; k++) send_byte(8'($urandom_range(1, 255)), 0);
        do_reset();
        check("midload_reset_map", map, 128'h0);
        check("midload_reset_rx_ready", 128'(rx_ready), 128'h1);
        op_tile(8'h85, 0);
        op_commit(0);
        frame_pulse();
        check("after_reset_opcode", map, 128'h20);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
